// File: rtl/uart_pkg.sv
// uart_pkg: widths and depths shared by the UART receiver, transmitter and their FIFOs
package uart_pkg;
    localparam int UartDataWidth = 8;
    localparam int UartFifoDepth = 16;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: register array with one synchronous write port and one asynchronous read port
module uart_fifo_mem #(
    parameter int DataWidth = 8,
    parameter int Depth = 16,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [AddrWidth-1:0] raddr,
    output logic [DataWidth-1:0] rdata
);
    logic [DataWidth-1:0] mem [Depth];
    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer with fill level, threshold and sticky overflow
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DataWidth = UartDataWidth,
    parameter int Depth = UartFifoDepth,
    parameter int Threshold = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     dv_i,
    input  logic [DataWidth-1:0]     data_i,
    input  logic                     flush_i,
    input  logic                     clr_ovf_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [DataWidth-1:0]     rd_data_o,
    output logic [$clog2(Depth):0]   level_o,
    output logic                     full_o,
    output logic                     thresh_o,
    output logic                     overflow_o
);
    localparam int AddrWidth = $clog2(Depth);
    logic [AddrWidth:0] wr_ptr, rd_ptr;
    logic push, pop, drop;
    always_comb begin
        rd_valid_o = wr_ptr != rd_ptr;
        level_o = wr_ptr - rd_ptr;
        full_o = wr_ptr == {~rd_ptr[AddrWidth], rd_ptr[AddrWidth-1:0]};
        thresh_o = level_o >= (AddrWidth+1)'(Threshold);
        // flush swallows any byte or pop arriving in the same cycle without flagging overflow
        push = dv_i && !full_o && !flush_i;
        drop = dv_i && full_o && !flush_i;
        pop = rd_valid_o && rd_ready_i && !flush_i;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            overflow_o <= 1'b0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= flush_i ? wr_ptr : pop ? rd_ptr + 1'b1 : rd_ptr;
            overflow_o <= drop || (overflow_o && !clr_ovf_i);
        end
    end
    uart_fifo_mem #(
        .DataWidth(DataWidth),
        .Depth(Depth),
        .AddrWidth(AddrWidth)
    ) u_mem (
        .clk_i(clk_i),
        .we(push),
        .waddr(wr_ptr[AddrWidth-1:0]),
        .wdata(data_i),
        .raddr(rd_ptr[AddrWidth-1:0]),
        .rdata(rd_data_o)
    );
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. Captures each received byte, signalled by the receiver's one-cycle data-valid pulse, into a circular buffer. Presents bytes to the bus/CPU side through a first-word-fall-through valid/ready interface. Reports fill level, a threshold flag for interrupt generation, and a sticky overflow flag.

Parameters:
DataWidth, 8, width of each stored byte; matches the receiver data width.
Depth, 16, number of entries; must be a power of two, at least 2.
Threshold, 8, level at or above which thresh_o asserts; range 1..Depth.
AddrWidth (localparam), $clog2(Depth), pointer index width.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  synchronous reset, active-low
dv_i  input  1  receiver data-valid pulse, one cycle per byte
data_i  input  DataWidth  received byte; sampled only when dv_i=1
flush_i  input  1  discard all stored bytes
clr_ovf_i  input  1  clear sticky overflow flag
rd_valid_o  output  1  head entry available (equals !empty)
rd_ready_i  input  1  consumer accepts head entry this cycle
rd_data_o  output  DataWidth  head entry, valid while rd_valid_o=1
level_o  output  AddrWidth+1  number of stored entries, 0..Depth
full_o  output  1  level_o == Depth
thresh_o  output  1  level_o >= Threshold
overflow_o  output  1  sticky: a byte was dropped

Behaviour:
- Interface fixed: one clock (clk_i); reset rst_ni is synchronous and active-low, sampled only on the rising edge of clk_i.
- Reset (rst_ni=0 at an edge): wr_ptr=0, rd_ptr=0, overflow=0. Outputs: rd_valid_o=0, level_o=0, full_o=0, thresh_o=0, overflow_o=0. Storage contents are not reset. After reset, rd_data_o is don't-care while rd_valid_o=0.
- Pointers: wr_ptr and rd_ptr are each AddrWidth+1 bits. Low AddrWidth bits index storage; the MSB is the wrap bit.
  - empty: pointers equal.
  - full: low bits equal and MSBs differ.
  - level_o = wr_ptr - rd_ptr, modulo 2^(AddrWidth+1).
  - All flags are derived combinationally from the registered pointers.
- Write: when dv_i=1 and full_o=0, store data_i at mem[wr_ptr] and increment wr_ptr.
- Drop: when dv_i=1 and full_o=1, discard the byte and set overflow at the next edge. A read in the same cycle does not rescue the write, because full is judged on the pre-edge state.
- Read: the pop condition is rd_valid_o && rd_ready_i; on pop, rd_ptr increments. rd_data_o = mem[rd_ptr[AddrWidth-1:0]] combinationally (first-word fall-through). rd_ready_i is ignored while empty.
- Latency: a byte written at edge N is visible on rd_valid_o/rd_data_o after edge N; zero extra cycles. A write into an empty FIFO cannot be popped in the same cycle.
- Simultaneous push and pop (not full, not empty): both pointers advance and level is unchanged.
- Wrap-around: pointers wrap naturally modulo 2^(AddrWidth+1); no special casing.
- flush_i=1: rd_ptr <= wr_ptr, so the FIFO becomes empty. A dv_i or pop in the same cycle is ignored, so that byte is lost but overflow is not set. overflow_o is unaffected.
- Overflow flag: set takes priority over clr_ovf_i in the same cycle. clr_ovf_i alone clears the flag at the next edge.
- Reset takes priority over flush, write, read and clear.
- A receiver dv_i pulse longer than one cycle is treated as multiple writes; the upstream block guarantees single-cycle pulses.
- No state machine beyond the pointer/flag registers. The storage array is written only on accepted writes.

Decomposition:
- Shared package uart_pkg holds:
  - UartDataWidth = 8, used by the receiver, transmitter and this block.
  - UartFifoDepth = 16.
- One natural sub-module: uart_fifo_mem, a simple dual-port register array (write port: en/addr/data; asynchronous read port: addr/data). The transmitter-side FIFO reuses it. Pointer and flag logic stays in uart_rx_fifo.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles, then release. Require rd_valid_o=0, level_o=0, full_o=0, thresh_o=0, overflow_o=0.
- Single byte: pulse dv_i with 0xA5. Next cycle rd_valid_o=1, rd_data_o=0xA5, level_o=1. Assert rd_ready_i for one cycle; then rd_valid_o=0, level_o=0.
- Fill and threshold: write 0x00..0x0F with no reads. thresh_o rises after the 8th write (level 8); full_o=1 at level 16. Drain all 16 and check the output order is 0x00..0x0F.
- Overflow: when full, pulse dv_i=0x77 with rd_ready_i=1 in the same cycle. Require:
  - the byte is dropped;
  - overflow_o=1 and level_o=15;
  - 0x77 never appears at rd_data_o.
  Then assert clr_ovf_i together with another dropped write; overflow_o must stay 1. clr_ovf_i alone then clears it.
- Wrap with concurrent push/pop: stream 40 bytes, pushing and popping every cycle after the first. Require level_o constant at 1 and in-order data across pointer wrap.
- Flush/reset mid-operation:
  - With level_o=5, assert flush_i together with dv_i. Next cycle level_o=0, overflow_o unchanged.
  - Refill to 3, then hold rst_ni=0 for 1 cycle. All outputs return to their reset values.
